onehot_regfile: RTL
===================

ONEHOT_REGFILE -- requirements
Module: onehot_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register index width; register count N = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register and data-port width.
REQ-003 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  write request this cycle.
REQ-008 SHALL have port wr_sel  input  N  one-hot write select, driven by the upstream index decoder.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_addr_a  input  ADDR_WIDTH  read port A binary index.
REQ-011 SHALL have port rd_addr_b  input  ADDR_WIDTH  read port B binary index.
REQ-012 SHALL have port rd_data_a  output  DATA_WIDTH  read port A data.
REQ-013 SHALL have port rd_data_b  output  DATA_WIDTH  read port B data.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of sel_err.
REQ-015 SHALL have port sel_err  output  1  sticky flag: malformed wr_sel seen with wr_en.
REQ-016 SHALL have port wr_count  output  8  count of committed writes, wraps 255 -> 0.

Function
REQ-017 A write SHALL be valid when wr_en=1 and wr_sel has exactly one bit set.
REQ-018 On a rising edge with a valid write to bit k, register k SHALL take wr_data; all other registers SHALL hold.
REQ-019 With ZERO_REG=1, a valid write to bit 0 SHALL be discarded: no sel_err, no wr_count increment.
REQ-020 When wr_en=1 and wr_sel is all-zero or has two or more bits set, no register SHALL change, and sel_err SHALL be 1 from the next edge.
REQ-021 sel_err SHALL remain 1 until an edge with clr_err=1; a new error on the same edge as clr_err SHALL leave sel_err=1 (set wins).
REQ-022 wr_en=0 SHALL ignore wr_sel entirely: no write, no error.
REQ-023 wr_count SHALL increment by 1 on each edge that commits a register write; 8-bit modulo wrap.
REQ-024 Read ports SHALL be combinational: rd_data_x = register[rd_addr_x] in the same cycle, zero-latency.
REQ-025 With ZERO_REG=1, rd_addr_x=0 SHALL return 0 regardless of stored contents or bypass.
REQ-026 With BYPASS=1, a read SHALL return wr_data in the same cycle when a valid committing write targets rd_addr_x.
REQ-027 With BYPASS=0, that read SHALL return the old contents, and the new value from the next cycle.
REQ-028 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-029 Malformed wr_sel SHALL never be forwarded by bypass logic.

Reset
REQ-030 While rst_n=0, all registers, sel_err and wr_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 A write presented on the edge where rst_n is low SHALL be discarded.
REQ-032 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset, then write i*0x11111111 to each index i=1..15 via wr_sel=1<<i, then read all indices on A and B -> each returns its pattern, index 0 returns 0, wr_count=15.
REQ-034 wr_en=1, wr_sel=0x0003, wr_data=0xDEADBEEF -> registers 0 and 1 unchanged, sel_err=1 next cycle; clr_err pulse -> sel_err=0; wr_sel=0x0000 with wr_en=1 -> sel_err=1.
REQ-035 BYPASS=1: write 0xCAFEF00D to index 5 with rd_addr_a=5 in the same cycle -> rd_data_a=0xCAFEF00D that cycle; BYPASS=0 -> old value that cycle, new value next cycle.
REQ-036 wr_sel=0x0001 with wr_data=0xFFFFFFFF -> rd_data_a(addr 0)=0, wr_count unchanged, sel_err=0.
REQ-037 Load index 3 = 0x12345678, then assert rst_n=0 mid-cycle while a write to index 3 is pending -> rd_data_a(addr 3)=0 before the next edge, sel_err=0, wr_count=0.
REQ-038 Commit 256 valid writes -> wr_count wraps to 0; simultaneous error and clr_err on one edge -> sel_err=1.

Source files
------------

// File: rtl/onehot_regfile.sv
// ----------------------------------------------------------------------------
// onehot_regfile
//   Register file with a one-hot write select and two combinational read ports.
//   The write select comes from an upstream index decoder. A select with zero
//   bits or several bits set is refused and raises a sticky error flag.
//
//   Parameters
//     ADDR_WIDTH : register index width; N = 2**ADDR_WIDTH registers
//     DATA_WIDTH : register / data port width
//     BYPASS     : 1 = a read of the register being written returns wr_data
//                  in the same cycle
//     ZERO_REG   : 1 = register 0 always reads 0 and writes to it are dropped
//
//   Ports
//     clk, rst_n           : clock; asynchronous active-low reset
//     wr_en, wr_sel        : write request with its one-hot target select
//     wr_data              : write data
//     rd_addr_a/b          : binary read indices
//     rd_data_a/b          : read data, zero latency
//     clr_err              : synchronous clear of sel_err (a new error wins)
//     sel_err              : sticky flag for a malformed select seen with wr_en
//     wr_count             : count of committed writes, 8-bit, wraps
// ----------------------------------------------------------------------------
module onehot_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    localparam int N         = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [N-1:0]          wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  clr_err,
    output logic                  sel_err,
    output logic [7:0]            wr_count
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [N-1:0][DATA_WIDTH-1:0] regs;
    logic                         sel_onehot;
    logic                         commit;
    logic                         err_set;
    logic                         sel_err_d, sel_err_q;
    logic [7:0]                   wr_count_d, wr_count_q;

    // x & (x-1) clears the lowest set bit; zero result plus nonzero x means
    // exactly one bit set.
    assign sel_onehot = (wr_sel != '0) &&
                        ((wr_sel & (wr_sel - {{(N-1){1'b0}}, 1'b1})) == '0);

    // A write to a hardwired zero register is legal but is not a commit.
    // rst_n gates commit so nothing is forwarded while reset is held.
    assign commit  = rst_n & wr_en & sel_onehot & ~(ZR & wr_sel[0]);
    assign err_set = wr_en & ~sel_onehot;

    // Per-register storage
    for (genvar k = 0; k < N; k++) begin : g_reg
        if (ZR && k == 0) begin : g_zero
            assign regs[k] = '0;
        end else begin : g_cell
            onehot_regfile_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (commit & wr_sel[k]),
                .d     (wr_data),
                .q     (regs[k])
            );
        end
    end

    // Read mux: hardwired zero first, then forwarding, then stored contents.
    function automatic logic [DATA_WIDTH-1:0] rd_mux(
        input logic [ADDR_WIDTH-1:0]        addr,
        input logic [N-1:0][DATA_WIDTH-1:0] r,
        input logic [N-1:0]                 sel,
        input logic                         cmt,
        input logic [DATA_WIDTH-1:0]        wdata
    );
        if (ZR && addr == '0)
            return '0;
        else if (BP && cmt && sel[addr])
            return wdata;
        else
            return r[addr];
    endfunction

    always_comb begin
        rd_data_a = rd_mux(rd_addr_a, regs, wr_sel, commit, wr_data);
        rd_data_b = rd_mux(rd_addr_b, regs, wr_sel, commit, wr_data);
    end

    always_comb begin
        sel_err_d = sel_err_q;
        if (clr_err) sel_err_d = 1'b0;
        if (err_set) sel_err_d = 1'b1;   // set wins over clear
        wr_count_d = wr_count_q + {7'd0, commit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            sel_err_q  <= sel_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign wr_count = wr_count_q;

endmodule

// ----------------------------------------------------------------------------
// onehot_regfile_cell
//   One storage register with load enable.
//   Ports: clk, rst_n (async low), we (load), d (data in), q (stored value).
// ----------------------------------------------------------------------------
module onehot_regfile_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (we) data_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q = data_q;

endmodule
